// File: rtl/cur_mb_fetch.sv
// Current-macroblock fetch engine: reads a 16x16 block as 64 word reads and
// emits one 128-bit pixel row per valid/ready transfer.
module cur_mb_fetch #(
   parameter int unsigned FRAME_WIDTH = 1920,
   parameter int unsigned FRAME_BASE  = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   mb_x,
   input  logic [7:0]   mb_y,
   output logic         mem_en,
   output logic [31:0]  mem_addr,
   input  logic [31:0]  mem_data,
   output logic         pix_valid,
   input  logic         pix_ready,
   output logic [3:0]   pix_row,
   output logic [127:0] pix_data,
   output logic         busy,
   output logic         done,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [31:0] FW       = 32'(FRAME_WIDTH);
   localparam logic [31:0] FB       = 32'(FRAME_BASE);
   localparam logic [31:0] MB_PITCH = 32'(16 * FRAME_WIDTH);

   state_t         state_q, state_d;
   logic [31:0]    base_q, base_d;
   logic [3:0]     row_q, row_d;
   logic [1:0]     word_q, word_d;
   logic [95:0]    asm_q, asm_d;
   logic           pix_valid_q, pix_valid_d;
   logic [3:0]     pix_row_q, pix_row_d;
   logic [127:0]   pix_data_q, pix_data_d;
   logic           done_q, done_d;

   logic           accept;
   logic           stall;

   // Handshake: a row transfers on any cycle with pix_valid && pix_ready; while
   // pix_valid is high and pix_ready low, pix_row/pix_data hold their value.
   assign accept = pix_valid_q && pix_ready;
   // Only the row-completing read needs a free output register.
   assign stall  = (word_q == 2'd3) && pix_valid_q && !pix_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         row_q       <= '0;
         word_q      <= '0;
         asm_q       <= '0;
         pix_valid_q <= 1'b0;
         pix_row_q   <= '0;
         pix_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         row_q       <= row_d;
         word_q      <= word_d;
         asm_q       <= asm_d;
         pix_valid_q <= pix_valid_d;
         pix_row_q   <= pix_row_d;
         pix_data_q  <= pix_data_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      row_d       = row_q;
      word_d      = word_q;
      asm_d       = asm_q;
      pix_valid_d = pix_valid_q;
      pix_row_d   = pix_row_q;
      pix_data_d  = pix_data_q;
      done_d      = 1'b0;
      mem_en      = 1'b0;
      mem_addr    = '0;

      // A reload below overrides this clear, so accept+reload keeps the new row.
      if (accept) begin
         pix_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = FB + ({24'd0, mb_y} * MB_PITCH) + {20'd0, mb_x, 4'd0};
               row_d   = '0;
               word_d  = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (!stall) begin
               mem_en   = 1'b1;
               mem_addr = base_q + ({28'd0, row_q} * FW) + {28'd0, word_q, 2'b00};
               if (word_q != 2'd3) begin
                  case (word_q)
                     2'd0:    asm_d[31:0]  = mem_data;
                     2'd1:    asm_d[63:32] = mem_data;
                     default: asm_d[95:64] = mem_data;
                  endcase
                  word_d = word_q + 2'd1;
               end else begin
                  pix_data_d  = {mem_data, asm_q};
                  pix_row_d   = row_q;
                  pix_valid_d = 1'b1;
                  word_d      = 2'd0;
                  row_d       = row_q + 4'd1;
                  if (row_q == 4'd15) begin
                     state_d = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            if (accept && (pix_row_q == 4'd15)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pix_valid = pix_valid_q;
   assign pix_row   = pix_row_q;
   assign pix_data  = pix_data_q;
   assign busy      = (state_q == FETCH) || (state_q == DRAIN);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cur_mb_fetch.sv
// Bench for cur_mb_fetch: address/row scoreboard fed from a frame-geometry
// model, plus directed timing scenarios and a randomized backpressure phase.
module tb_cur_mb_fetch;

   localparam int FW = 64;
   localparam int FB = 0;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   mb_x = '0;
   logic [7:0]   mb_y = '0;
   logic         mem_en;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_data;
   logic         pix_valid;
   logic         pix_ready = 1'b1;
   logic [3:0]   pix_row;
   logic [127:0] pix_data;
   logic         busy;
   logic         done;
   logic [1:0]   dbg_state;

   cur_mb_fetch #(.FRAME_WIDTH(FW), .FRAME_BASE(FB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mb_x(mb_x), .mb_y(mb_y),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_row(pix_row),
      .pix_data(pix_data), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // Memory model: every byte holds the low 8 bits of its own address.
   assign mem_data = {mem_addr[7:0] + 8'd3, mem_addr[7:0] + 8'd2,
                      mem_addr[7:0] + 8'd1, mem_addr[7:0]};

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [131:0] exp_q[$];
   logic [31:0]  addr_q[$];
   int           acc_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           t0 = 0;
   int           en_cnt = 0;
   int           done_cnt = 0;
   int           done_cyc = -1;
   logic         done_busy = 1'b0;
   int           rdy_mode = 0;
   int           win_lo = 0;
   int           win_hi = -1;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] mb_base(input int x, input int y);
      return 32'(FB) + 32'(y) * 32'(16 * FW) + 32'(x) * 32'd16;
   endfunction

   task automatic push_model(input int x, input int y);
      logic [31:0]  b;
      logic [31:0]  a;
      logic [127:0] d;
      b = mb_base(x, y);
      for (int r = 0; r < 16; r++) begin
         for (int w = 0; w < 4; w++) addr_q.push_back(b + 32'(r * FW) + 32'(4 * w));
         for (int p = 0; p < 16; p++) begin
            a = b + 32'(r * FW) + 32'(p);
            d[8*p +: 8] = a[7:0];
         end
         exp_q.push_back({4'(r), d});
      end
   endtask

   // ---------------- drivers ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ($urandom_range(0, 3) != 0);
            default: pix_ready = !(((cyc - t0) >= win_lo) && ((cyc - t0) <= win_hi));
         endcase
      end
   end

   task automatic start_mb(input int x, input int y);
      @(posedge clk);
      #1;
      start = 1'b1;
      mb_x = 8'(x);
      mb_y = 8'(y);
      t0 = cyc;
      en_cnt = 0;
      acc_q.delete();
      push_model(x, y);
      @(posedge clk);
      #1;
      start = 1'b0;
      mb_x = 8'($urandom);
      mb_y = 8'($urandom);
   endtask

   task automatic pulse_start(input int x, input int y);
      @(posedge clk);
      #1;
      start = 1'b1;
      mb_x = 8'(x);
      mb_y = 8'(y);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic at_rel(input int n);
      do @(negedge clk); while (cyc < t0 + n);
   endtask

   task automatic wait_done(input int exp_rel);
      int lim;
      lim = 0;
      do begin
         @(negedge clk);
         lim++;
      end while (!done && lim < 2000);
      if (!done) begin
         check("done_timeout", 1'b0, 1'b1);
      end else begin
         if (exp_rel >= 0) check("done_cycle", 32'(cyc - t0), 32'(exp_rel));
         check("busy_at_done", busy, 1'b0);
         check("mem_en_count", 32'(en_cnt), 32'd64);
         check("rows_left", 32'(exp_q.size()), 32'd0);
         check("addrs_left", 32'(addr_q.size()), 32'd0);
         @(negedge clk);
         check("done_pulse_width", done, 1'b0);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            en_cnt++;
            if (addr_q.size() == 0) check("addr_unexpected", 1'b1, 1'b0);
            else check("mem_addr", mem_addr, addr_q.pop_front());
         end else begin
            check("mem_addr_idle", mem_addr, 32'd0);
         end
         if (pix_valid) begin
            if (exp_q.size() == 0) begin
               check("row_unexpected", 1'b1, 1'b0);
            end else begin
               check("row", {pix_row, pix_data}, exp_q[0]);
               if (pix_ready) begin
                  void'(exp_q.pop_front());
                  acc_q.push_back(cyc - t0);
               end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_busy = busy;
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int dc;
      repeat (2) @(negedge clk);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_pix", {pix_valid, pix_row, pix_data}, '0);
      check("rst_busy_done", {busy, done}, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic fetch
      rdy_mode = 0;
      start_mb(1, 2);
      at_rel(1);
      check("first_en", mem_en, 1'b1);
      check("first_addr", mem_addr, 32'd2064);
      at_rel(5);
      check("row0_valid", {pix_valid, pix_row}, {1'b1, 4'd0});
      check("row0_word0", pix_data[31:0], 32'h13121110);
      at_rel(9);
      check("row1_valid", {pix_valid, pix_row}, {1'b1, 4'd1});
      check("row1_word0", pix_data[31:0], 32'h53525150);
      wait_done(66);
      check("accept_count", 32'(acc_q.size()), 32'd16);
      for (int r = 0; r < 16 && r < acc_q.size(); r++)
         check("row_cycle", 32'(acc_q[r]), 32'(4 * r + 5));

      // Backpressure on row 0
      rdy_mode = 2; win_lo = 5; win_hi = 14;
      start_mb(4, 1);
      for (int r = 8; r <= 14; r++) begin
         at_rel(r);
         check("stall_mem_en", mem_en, 1'b0);
      end
      at_rel(15);
      check("stall_release_en", mem_en, 1'b1);
      wait_done(73);

      // Start while busy is ignored
      rdy_mode = 0;
      start_mb(1, 1);
      at_rel(19);
      pulse_start(3, 0);
      wait_done(66);

      // Async reset mid-fetch
      start_mb(5, 1);
      at_rel(29);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_mem", {mem_en, mem_addr}, '0);
      check("arst_pix", {pix_valid, pix_row, pix_data}, '0);
      check("arst_busy_done", {busy, done, dbg_state}, '0);
      exp_q.delete();
      addr_q.delete();
      dc = done_cnt;
      repeat (3) begin
         @(negedge clk);
         check("done_in_reset", done, 1'b0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("no_done_after_reset", 32'(done_cnt), 32'(dc));
      start_mb(0, 0);
      at_rel(1);
      check("post_reset_addr", {mem_en, mem_addr}, {1'b1, 32'd0});
      wait_done(66);

      // Back-to-back: second start in the done cycle
      start_mb(0, 3);
      at_rel(65);
      start_mb(2, 0);
      check("b2b_done_cycle", 32'(done_cyc), 32'(t0));
      check("b2b_busy_at_done", done_busy, 1'b0);
      at_rel(1);
      check("b2b_first_addr", {mem_en, mem_addr}, {1'b1, 32'd32});
      wait_done(66);

      // Last-row stall in DRAIN
      rdy_mode = 2; win_lo = 65; win_hi = 69;
      start_mb(7, 5);
      at_rel(67);
      check("drain_busy", {busy, dbg_state}, {1'b1, 2'd2});
      check("drain_row15", {pix_valid, pix_row}, {1'b1, 4'd15});
      wait_done(71);

      // Randomized macroblocks under random backpressure
      rdy_mode = 1;
      repeat (4) begin
         start_mb($urandom_range(0, 255), $urandom_range(0, 255));
         wait_done(-1);
      end

      rdy_mode = 0;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
